// File: rtl/fwd_sel_reg.sv
// Registered N-way operand forwarding selector with stall hold buffer.
// Flags and counts multi-hot selects; one instance per read port.
module fwd_sel_reg #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NSRC*WIDTH-1:0] srcs_i,
  input  logic [NSRC-2:0]       sel_i,
  input  logic                  in_valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic                  out_valid_o,
  output logic                  hold_active_o,
  output logic                  sel_err_o,
  output logic [7:0]            err_cnt_o
);

  logic [WIDTH-1:0] src0;
  logic [WIDTH-1:0] pick_one;
  logic [WIDTH-1:0] pick;
  logic [4:0]       hot_cnt;
  logic             multi_hot;
  logic             bad_sel;
  logic [WIDTH-1:0] hold_data;

  assign src0 = srcs_i[WIDTH-1:0];

  // sel bit j maps to source NSRC-1-j; MSB picks source 1
  always_comb begin
    pick_one = src0;
    hot_cnt  = '0;
    for (int j = 0; j < NSRC-1; j++) begin
      if (sel_i[j]) begin
        hot_cnt  = hot_cnt + 5'd1;
        pick_one = srcs_i[(NSRC-1-j)*WIDTH +: WIDTH];
      end
    end
  end

  assign multi_hot = (hot_cnt > 5'd1);
  assign pick      = (hot_cnt == 5'd1) ? pick_one : src0;
  assign bad_sel   = multi_hot & in_valid_i & ~flush_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_err_o <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      sel_err_o <= bad_sel;
      if (bad_sel && err_cnt_o != 8'hff)
        err_cnt_o <= err_cnt_o + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_data_o    <= '0;
      out_valid_o   <= 1'b0;
      hold_active_o <= 1'b0;
      hold_data     <= '0;
    end else if (flush_i) begin
      out_data_o    <= '0;
      out_valid_o   <= 1'b0;
      hold_active_o <= 1'b0;
      hold_data     <= '0;
    end else if (stall_i) begin
      // first capture wins until the stall releases
      if (!hold_active_o && in_valid_i) begin
        hold_data     <= pick;
        hold_active_o <= 1'b1;
      end
    end else if (hold_active_o) begin
      out_data_o    <= hold_data;
      out_valid_o   <= 1'b1;
      hold_active_o <= 1'b0;
    end else begin
      out_data_o  <= pick;
      out_valid_o <= in_valid_i;
    end
  end

endmodule
